// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer driving an external combinational ALU,
// with an 8-entry register file, a retire pulse and a debug read port.
module alu_sequencer #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  output logic         alu_en,
  output logic [2:0]   alu_op,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  input  logic [n-1:0] alu_out,
  output logic         done,
  output logic [n-1:0] result,
  input  logic [2:0]   dbg_addr,
  output logic [n-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int IMM_W = (n > 10) ? n : 10;

  state_t       state_q, state_d;
  logic [n-1:0] rf_q [8];
  logic [n-1:0] rf_d [8];
  logic         alu_en_q, alu_en_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic [n-1:0] alu_a_q, alu_a_d;
  logic [n-1:0] alu_b_q, alu_b_d;
  logic [n-1:0] result_q, result_d;
  logic         done_q, done_d;
  logic [2:0]   rd_q, rd_d;
  logic         ldi_q, ldi_d;
  logic [n-1:0] imm_q, imm_d;

  // Zero-extends (or truncates) the 10-bit LDI immediate to the datapath width.
  function automatic logic [n-1:0] zext_imm(input logic [9:0] imm);
    logic [IMM_W-1:0] wide;
    wide       = '0;
    wide[9:0]  = imm;
    return wide[n-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    rf_d     = rf_q;
    alu_en_d = alu_en_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    result_d = result_q;
    done_d   = 1'b0;
    rd_d     = rd_q;
    ldi_d    = ldi_q;
    imm_d    = imm_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          rd_d = instr[12:10];
          case (instr[15:13])
            3'b000: begin
              ldi_d   = 1'b0;
              done_d  = 1'b1;
              state_d = WB;
            end
            3'b001: begin
              ldi_d   = 1'b1;
              imm_d   = zext_imm(instr[9:0]);
              done_d  = 1'b1;
              state_d = WB;
            end
            default: begin
              // Operands are sampled now, so rd==ra/rb sees the pre-write value.
              ldi_d    = 1'b0;
              alu_en_d = 1'b1;
              alu_op_d = instr[15:13];
              alu_a_d  = rf_q[instr[9:7]];
              alu_b_d  = rf_q[instr[6:4]];
              state_d  = EXEC;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rf_d[rd_q] = alu_out;
        result_d   = alu_out;
        alu_en_d   = 1'b0;
        done_d     = 1'b1;
        state_d    = WB;
      end
      WB: begin
        // LDI commits on the way out of WB so a reset during WB drops it.
        if (ldi_q) begin
          rf_d[rd_q] = imm_q;
          result_d   = imm_q;
        end else begin
          result_d = result_q;
        end
        ldi_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rf_q     <= '{default: '0};
      alu_en_q <= 1'b0;
      alu_op_q <= 3'b000;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      rd_q     <= 3'b000;
      ldi_q    <= 1'b0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      rf_q     <= rf_d;
      alu_en_q <= alu_en_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      result_q <= result_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      ldi_q    <= ldi_d;
      imm_q    <= imm_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_en      = alu_en_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign done        = done_q;
  assign result      = result_q;
  assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a reference register file predicts each
// retired value at accept time; results are compared when done pulses.
module tb_alu_sequencer;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid;
  logic         instr_ready;
  logic [15:0]  instr;
  logic         alu_en;
  logic [2:0]   alu_op;
  logic [N-1:0] alu_a, alu_b, alu_out;
  logic         done;
  logic [N-1:0] result;
  logic [2:0]   dbg_addr;
  logic [N-1:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]   rd;
    logic [N-1:0] val;
    logic         wr;
    int           lat;
  } exp_t;

  exp_t         sbq[$];
  logic [N-1:0] mrf [8];
  logic [N-1:0] mres;

  alu_sequencer #(.n(N)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .done(done), .result(result), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU: 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 NOT a
  always_comb begin
    alu_out = '0;
    if (alu_en) begin
      case (alu_op)
        3'd2: alu_out = alu_a + alu_b;
        3'd3: alu_out = alu_a - alu_b;
        3'd4: alu_out = alu_a & alu_b;
        3'd5: alu_out = alu_a | alu_b;
        3'd6: alu_out = alu_a ^ alu_b;
        3'd7: alu_out = ~alu_a;
        default: alu_out = '0;
      endcase
    end
  end

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 4'b0000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
    return {3'b001, rd, imm};
  endfunction

  function automatic exp_t predict(input logic [15:0] w);
    exp_t e;
    logic [N-1:0] a, b;
    a     = mrf[w[9:7]];
    b     = mrf[w[6:4]];
    e.rd  = w[12:10];
    e.wr  = 1'b1;
    e.lat = 2;
    case (w[15:13])
      3'd0: begin e.wr = 1'b0; e.val = mres; e.lat = 1; end
      3'd1: begin e.val = {{(N-10){1'b0}}, w[9:0]}; e.lat = 1; end
      3'd2: e.val = a + b;
      3'd3: e.val = a - b;
      3'd4: e.val = a & b;
      3'd5: e.val = a | b;
      3'd6: e.val = a ^ b;
      default: e.val = ~a;
    endcase
    return e;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    mres = '0;
  endtask

  // Issues one instruction, then checks latency, pulse width, result and register.
  task automatic send(input logic [15:0] w, input string name);
    exp_t e;
    int   waited;
    int   n;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (!instr_ready) begin
      miscompares++;
      $display("FAIL %s accept: instr_ready=%0b after %0d cycles, need 1", name, instr_ready, waited);
      instr_valid = 1'b0;
      return;
    end
    sbq.push_back(predict(w));
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 10);
    e = sbq.pop_front();
    vectors++;
    if (done !== 1'b1 || n != e.lat) begin
      miscompares++;
      $display("FAIL %s latency: done=%b after %0d cycles, need done=1 after %0d", name, done, n, e.lat);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || instr_ready !== 1'b1 || alu_en !== 1'b0) begin
      miscompares++;
      $display("FAIL %s post_wb: done=%b ready=%b alu_en=%b, need 0 1 0", name, done, instr_ready, alu_en);
    end
    if (e.wr) mrf[e.rd] = e.val;
    mres = e.val;
    dbg_addr = e.rd;
    #1;
    vectors++;
    if (result !== mres || dbg_data !== mrf[e.rd]) begin
      miscompares++;
      $display("FAIL %s value: result=%h r%0d=%h, need result=%h r%0d=%h",
               name, result, e.rd, dbg_data, mres, e.rd, mrf[e.rd]);
    end
  endtask

  task automatic check_reg(input logic [2:0] r, input logic [N-1:0] v, input string name);
    dbg_addr = r;
    #1;
    vectors++;
    if (dbg_data !== v) begin
      miscompares++;
      $display("FAIL %s: r%0d=%h, need %h", name, r, dbg_data, v);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    dbg_addr = 3'd0;
    model_reset();
    #12;
    vectors++;
    if (done !== 1'b0 || alu_en !== 1'b0 || alu_op !== 3'b000 || alu_a !== '0 ||
        alu_b !== '0 || result !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: done=%b en=%b op=%b a=%h b=%h res=%h, need all 0",
               done, alu_en, alu_op, alu_a, alu_b, result);
    end
    for (int i = 0; i < 8; i++) check_reg(i[2:0], '0, "reset_rf");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: instr_ready=%b, need 1", instr_ready);
    end
  endtask

  task automatic test_ldi_add;
    send(ldi(3'd1, 10'd5), "ldi_r1");
    send(ldi(3'd2, 10'd3), "ldi_r2");
    send(mk(3'd2, 3'd3, 3'd1, 3'd2), "add_r3");
    check_reg(3'd3, 16'd8, "add_r3_eq8");
    send(ldi(3'd7, 10'h3FF), "ldi_max_imm");
    check_reg(3'd7, 16'h03FF, "ldi_zext");
  endtask

  task automatic test_alu_ops;
    send(mk(3'd3, 3'd4, 3'd2, 3'd1), "sub_r4");
    check_reg(3'd4, 16'hFFFE, "sub_wrap");
    send(mk(3'd7, 3'd5, 3'd1, 3'd0), "not_r5");
    check_reg(3'd5, 16'hFFFA, "not_r5");
    send(mk(3'd6, 3'd6, 3'd1, 3'd2), "xor_r6");
    check_reg(3'd6, 16'd6, "xor_r6");
    send(mk(3'd4, 3'd0, 3'd4, 3'd7), "and_r0");
    send(mk(3'd5, 3'd0, 3'd0, 3'd5), "or_r0");
    send(mk(3'd2, 3'd0, 3'd4, 3'd4), "add_carry_out");
  endtask

  task automatic test_self_operand;
    send(ldi(3'd1, 10'd7), "ldi_r1_7");
    send(mk(3'd2, 3'd1, 3'd1, 3'd1), "add_r1_self");
    check_reg(3'd1, 16'd14, "self_r1_14");
    vectors++;
    if (result !== 16'd14) begin
      miscompares++;
      $display("FAIL self_result: result=%h, need 000e", result);
    end
  endtask

  task automatic test_nop;
    send(ldi(3'd2, 10'd9), "ldi_r2_9");
    send(mk(3'd0, 3'd2, 3'd0, 3'd0), "nop_rd2");
    check_reg(3'd2, 16'd9, "nop_r2_kept");
  endtask

  task automatic test_back_to_back;
    logic [15:0] words[3];
    int          acc_t[3];
    int          k, t, dones;
    exp_t        e;
    words[0] = mk(3'd2, 3'd3, 3'd1, 3'd2);
    words[1] = mk(3'd2, 3'd3, 3'd3, 3'd3);
    words[2] = mk(3'd3, 3'd4, 3'd3, 3'd1);
    k = 0; t = 0; dones = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = words[0];
    while ((k < 3 || sbq.size() > 0) && t < 40) begin
      if (done) begin
        e = sbq.pop_front();
        dones++;
        if (e.wr) mrf[e.rd] = e.val;
        mres = e.val;
        vectors++;
        if (result !== e.val) begin
          miscompares++;
          $display("FAIL b2b_result%0d: result=%h, need %h", dones, result, e.val);
        end
      end
      if (k < 3 && instr_ready) begin
        sbq.push_back(predict(words[k]));
        acc_t[k] = t;
        k++;
      end
      @(posedge clk);
      #1;
      if (k < 3) instr = words[k];
      else instr_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    instr_valid = 1'b0;
    vectors++;
    if (k != 3 || dones != 3 || acc_t[1] - acc_t[0] != 3 || acc_t[2] - acc_t[1] != 3) begin
      miscompares++;
      $display("FAIL b2b_spacing: accepts=%0d dones=%0d gaps=%0d,%0d, need 3 3 3,3",
               k, dones, acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
    end
    check_reg(3'd3, mrf[3], "b2b_r3");
    check_reg(3'd4, mrf[4], "b2b_r4");
  endtask

  task automatic test_reset_mid_exec;
    int seen_done;
    @(negedge clk);
    instr = mk(3'd2, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (alu_en !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b1 || result !== '0) begin
      miscompares++;
      $display("FAIL rst_async: en=%b done=%b ready=%b res=%h, need 0 0 1 0",
               alu_en, done, instr_ready, result);
    end
    model_reset();
    for (int i = 0; i < 8; i++) check_reg(i[2:0], '0, "rst_rf_clear");
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    vectors++;
    if (seen_done != 0 || instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_abort: done pulses=%0d ready=%b, need 0 and 1", seen_done, instr_ready);
    end
    check_reg(3'd3, '0, "rst_r3_zero");
    send(ldi(3'd3, 10'd21), "post_rst_ldi");
  endtask

  initial begin
    test_reset();
    test_ldi_add();
    test_alu_ops();
    test_self_operand();
    test_nop();
    test_back_to_back();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
